// File: rtl/rf_ctrl_pkg.sv
// Shared widths and FSM state type for the register-file write-port controller.
package rf_ctrl_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_COUNT = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    function automatic logic is_last_reg(input logic [ADDR_W-1:0] addr);
        return addr == ADDR_W'(REG_COUNT - 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the last-grant pointer only moves when en_i accepts a grant.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    // last_q = 1 means requester 1 won last, so requester 0 is favoured next.
    logic last_q, last_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (en_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rf_write_ctrl.sv
// Owns the register-file write port: round-robin writeback arbitration between ALU and
// memory load, plus a 32-cycle clear sequence started on command or after reset.
module rf_write_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter bit R0_WRITABLE    = 1'b0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] Data0,
    input  logic              Req1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Data1,
    input  logic              ClrReq,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              WrEn,
    output logic [ADDR_W-1:0] Awr,
    output logic [DATA_W-1:0] Din,
    output logic              Busy,
    output logic              ClrDone
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] awr_q, awr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              wr_en_q, wr_en_d;
    logic              clr_done_q, clr_done_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        elig;
    logic [1:0]        arb_gnt;
    logic              arb_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // A requester whose grant is showing this cycle is still dropping Req; mask it.
    assign elig = {Req1 & ~gnt_q[1], Req0 & ~gnt_q[0]};

    // The ClrDone cycle doubles as the first arbitration slot after a clear.
    assign arb_en = ((state_q == IDLE) && !ClrReq) || ((state_q == CLEAR) && clr_done_q);

    rr_arb2 u_arb (
        .clk_i (Clk),
        .rst_i (Rst),
        .req_i (elig),
        .en_i  (arb_en),
        .gnt_o (arb_gnt)
    );

    assign sel_addr = arb_gnt[1] ? Addr1 : Addr0;
    assign sel_data = arb_gnt[1] ? Data1 : Data0;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (ClrReq) state_d = CLEAR;
            CLEAR: if (clr_done_q) state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en_d    = 1'b0;
        awr_d      = awr_q;
        din_d      = din_q;
        gnt_d      = 2'b00;
        clr_done_d = 1'b0;
        cnt_d      = cnt_q;
        if ((state_q == CLEAR) && !clr_done_q) begin
            wr_en_d    = 1'b1;
            awr_d      = cnt_q;
            din_d      = '0;
            clr_done_d = is_last_reg(cnt_q);
            cnt_d      = cnt_q + ADDR_W'(1);
        end else if ((state_q == IDLE) && ClrReq) begin
            // Address 0 is written on the ClrReq edge itself, so the counter resumes at 1.
            wr_en_d = 1'b1;
            awr_d   = '0;
            din_d   = '0;
            cnt_d   = ADDR_W'(1);
        end else if (arb_gnt != 2'b00) begin
            gnt_d   = arb_gnt;
            awr_d   = sel_addr;
            din_d   = sel_data;
            wr_en_d = R0_WRITABLE || (sel_addr != '0);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_en_q    <= 1'b0;
            awr_q      <= '0;
            din_q      <= '0;
            gnt_q      <= 2'b00;
            clr_done_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            wr_en_q    <= wr_en_d;
            awr_q      <= awr_d;
            din_q      <= din_d;
            gnt_q      <= gnt_d;
            clr_done_q <= clr_done_d;
            cnt_q      <= cnt_d;
        end
    end

    assign Gnt0    = gnt_q[0];
    assign Gnt1    = gnt_q[1];
    assign WrEn    = wr_en_q;
    assign Awr     = awr_q;
    assign Din     = din_q;
    assign ClrDone = clr_done_q;
    assign Busy    = (state_q == CLEAR);

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Self-checking bench for rf_write_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_rf_write_ctrl;

    localparam bit TbClearOnReset = 1'b1;
    localparam bit TbR0Writable   = 1'b0;
    localparam logic [41:0] RstVec = {3'b000, 5'd0, 32'd0, 1'b1, 1'b0};

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Req0, Req1, ClrReq;
    logic [4:0]  Addr0, Addr1;
    logic [31:0] Data0, Data1;
    logic        Gnt0, Gnt1, WrEn, Busy, ClrDone;
    logic [4:0]  Awr;
    logic [31:0] Din;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    rf_write_ctrl #(
        .CLEAR_ON_RESET (TbClearOnReset),
        .R0_WRITABLE    (TbR0Writable)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Req0    (Req0),
        .Addr0   (Addr0),
        .Data0   (Data0),
        .Req1    (Req1),
        .Addr1   (Addr1),
        .Data1   (Data1),
        .ClrReq  (ClrReq),
        .Gnt0    (Gnt0),
        .Gnt1    (Gnt1),
        .WrEn    (WrEn),
        .Awr     (Awr),
        .Din     (Din),
        .Busy    (Busy),
        .ClrDone (ClrDone)
    );

    // Reference model: pending clear addresses in a queue, last winner as an integer.
    int          m_clr[$];
    bit          m_busy, m_gnt0, m_gnt1, m_wren, m_done;
    logic [4:0]  m_awr;
    logic [31:0] m_din;
    int          m_last;

    function automatic void model_fill_clear();
        m_clr.delete();
        for (int a = 0; a < 32; a++) m_clr.push_back(a);
    endfunction

    function automatic void model_reset();
        m_clr.delete();
        if (TbClearOnReset) model_fill_clear();
        m_busy = TbClearOnReset;
        {m_gnt0, m_gnt1, m_wren, m_done} = 4'b0;
        m_awr  = '0;
        m_din  = '0;
        m_last = 1;
    endfunction

    function automatic void model_arbitrate();
        bit e0 = Req0 && !m_gnt0;
        bit e1 = Req1 && !m_gnt1;
        int w = -1;
        if (e0 && e1) w = 1 - m_last;
        else if (e0) w = 0;
        else if (e1) w = 1;
        {m_gnt0, m_gnt1, m_wren, m_done} = 4'b0;
        if (w >= 0) begin
            m_last = w;
            m_gnt0 = (w == 0);
            m_gnt1 = (w == 1);
            m_awr  = (w == 1) ? Addr1 : Addr0;
            m_din  = (w == 1) ? Data1 : Data0;
            m_wren = TbR0Writable || (m_awr != 0);
        end
    endfunction

    function automatic void model_clear_write();
        m_awr  = 5'(m_clr.pop_front());
        m_din  = '0;
        m_wren = 1'b1;
        m_gnt0 = 1'b0;
        m_gnt1 = 1'b0;
        m_done = (m_clr.size() == 0);
    endfunction

    function automatic void model_step();
        if (m_busy && m_clr.size() > 0) begin
            model_clear_write();
        end else if (m_busy) begin
            m_busy = 1'b0;
            model_arbitrate();
        end else if (ClrReq) begin
            model_fill_clear();
            m_busy = 1'b1;
            model_clear_write();
        end else begin
            model_arbitrate();
        end
    endfunction

    function automatic logic [41:0] obs_vec();
        return {Gnt0, Gnt1, WrEn, Awr, Din, Busy, ClrDone};
    endfunction

    function automatic logic [41:0] exp_vec();
        return {m_gnt0, m_gnt1, m_wren, m_awr, m_din, m_busy, m_done};
    endfunction

    task automatic tick();
        if (Rst) model_reset();
        else model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        model_reset();
        tick();
        tick();
        checks++;
        if (obs_vec() !== RstVec) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), RstVec);
        end
        Rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++;
            if (WrEn !== 1'b1 || Awr !== i[4:0] || Din !== 32'd0 || Busy !== 1'b1 ||
                ClrDone !== (i == 31) || Gnt0 !== 1'b0 || Gnt1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_clear[%0d]: got %h want awr=%0d wren=1 din=0 busy=1",
                         i, obs_vec(), i);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_clear_model[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        tick();
        checks++;
        if (Busy !== 1'b0 || WrEn !== 1'b0 || ClrDone !== 1'b0) begin
            errors++;
            $display("FAIL reset_clear_end: got busy=%b wren=%b done=%b want 0 0 0",
                     Busy, WrEn, ClrDone);
        end
    endtask

    task automatic test_single();
        Addr0 = 5'd1;
        Data0 = 32'h2232;
        Req0  = 1'b1;
        tick();
        checks++;
        if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0 || WrEn !== 1'b1 || Awr !== 5'd1 ||
            Din !== 32'h2232) begin
            errors++;
            $display("FAIL single_grant: got %h want gnt0=1 wren=1 awr=1 din=2232", obs_vec());
        end
        tick();
        checks++;
        if (Gnt0 !== 1'b0 || WrEn !== 1'b0 || Awr !== 5'd1 || Din !== 32'h2232) begin
            errors++;
            $display("FAIL single_no_regrant: got %h want gnt0=0 wren=0 awr/din held", obs_vec());
        end
        Req0 = 1'b0;
        tick();
    endtask

    task automatic test_r0();
        Addr1 = 5'd0;
        Data1 = $urandom;
        Req1  = 1'b1;
        tick();
        checks++;
        if (Gnt1 !== 1'b1 || Gnt0 !== 1'b0 || WrEn !== 1'b0) begin
            errors++;
            $display("FAIL r0_suppress: got gnt1=%b gnt0=%b wren=%b want 1 0 0", Gnt1, Gnt0, WrEn);
        end
        Req1 = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        Addr0 = 5'd2; Data0 = 32'hAAAA; Req0 = 1'b1;
        Addr1 = 5'd4; Data1 = 32'h5555; Req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (Gnt0 !== (i % 2 == 0) || Gnt1 !== (i % 2 == 1) || WrEn !== 1'b1 ||
                Awr !== ((i % 2 == 0) ? 5'd2 : 5'd4) ||
                Din !== ((i % 2 == 0) ? 32'hAAAA : 32'h5555)) begin
                errors++;
                $display("FAIL contention[%0d]: got %h want winner %0d", i, obs_vec(), i % 2);
            end
        end
        Req0 = 1'b0;
        Req1 = 1'b0;
        tick();
    endtask

    task automatic test_clr_vs_req();
        Addr0  = 5'd7;
        Data0  = $urandom;
        Req0   = 1'b1;
        ClrReq = 1'b1;
        tick();
        ClrReq = 1'b0;
        checks++;
        if (Gnt0 !== 1'b0 || WrEn !== 1'b1 || Awr !== 5'd0 || Din !== 32'd0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_priority: got %h want clear write to 0, no grant", obs_vec());
        end
        for (int i = 1; i < 32; i++) begin
            tick();
            checks++;
            if (Gnt0 !== 1'b0 || WrEn !== 1'b1 || Awr !== i[4:0] || ClrDone !== (i == 31)) begin
                errors++;
                $display("FAIL clr_seq[%0d]: got %h want awr=%0d no grant", i, obs_vec(), i);
            end
        end
        tick();
        checks++;
        if (Gnt0 !== 1'b1 || Busy !== 1'b0 || WrEn !== 1'b1 || Awr !== 5'd7 || Din !== Data0) begin
            errors++;
            $display("FAIL clr_then_grant: got %h want gnt0=1 busy=0 awr=7", obs_vec());
        end
        Req0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        ClrReq = 1'b1;
        tick();
        ClrReq = 1'b0;
        n = 0;
        while (Awr !== 5'd10 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (Awr !== 5'd10) begin
            errors++;
            $display("FAIL midclr_reach10: got awr=%0d want 10 within 40 cycles", Awr);
        end
        Rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs_vec() !== RstVec) begin
            errors++;
            $display("FAIL midclr_async_reset: got %h want %h", obs_vec(), RstVec);
        end
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (Awr !== i[4:0] || WrEn !== 1'b1 || Busy !== 1'b1) begin
                errors++;
                $display("FAIL midclr_restart[%0d]: got awr=%0d wren=%b want awr=%0d wren=1",
                         i, Awr, WrEn, i);
            end
        end
        ClrReq = 1'b1;
        tick();
        ClrReq = 1'b0;
        checks++;
        if (Awr !== 5'd5 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL midclr_clrreq_ignored: got awr=%0d busy=%b want 5 1", Awr, Busy);
        end
        n = 0;
        while (ClrDone !== 1'b1 && n < 40) begin
            tick();
            n++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midclr_model: got %h want %h", obs_vec(), exp_vec());
            end
        end
        checks++;
        if (ClrDone !== 1'b1 || Awr !== 5'd31) begin
            errors++;
            $display("FAIL midclr_done: got done=%b awr=%0d want 1 31", ClrDone, Awr);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (Gnt0) begin
                if ($urandom_range(1) == 1) Req0 = 1'b0;
                else begin Addr0 = 5'($urandom); Data0 = $urandom; end
            end else if (!Req0 && $urandom_range(99) < 45) begin
                Req0  = 1'b1;
                Addr0 = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
                Data0 = $urandom;
            end
            if (Gnt1) begin
                if ($urandom_range(1) == 1) Req1 = 1'b0;
                else begin Addr1 = 5'($urandom); Data1 = $urandom; end
            end else if (!Req1 && $urandom_range(99) < 45) begin
                Req1  = 1'b1;
                Addr1 = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
                Data1 = $urandom;
            end
            ClrReq = ($urandom_range(99) < 2);
        end
        Req0   = 1'b0;
        Req1   = 1'b0;
        ClrReq = 1'b0;
        tick();
    endtask

    initial begin
        Rst    = 1'b1;
        Req0   = 1'b0;
        Req1   = 1'b0;
        ClrReq = 1'b0;
        Addr0  = '0;
        Addr1  = '0;
        Data0  = '0;
        Data1  = '0;
        test_reset();
        test_single();
        test_r0();
        test_contention();
        test_clr_vs_req();
        test_reset_mid_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_ctrl.md
# rf_write_ctrl

Write-port controller for the 32×32 register file. It owns the single write port (`WrEn`/`Awr`/`Din`) and shares it between two writeback requesters (ALU and memory load) with a round-robin arbiter. It also runs a 32-cycle clear sequence that zeroes every register, either on command or after reset. It sits between the writeback stage and the `RegisterFile` write inputs; the read ports are untouched.

## Interface
- `CLEAR_ON_RESET`, default 1: start the clear sequence automatically when reset is released.
- `R0_WRITABLE`, default 0: when 0, requester writes to address 0 are granted but suppressed (`WrEn` stays 0).
- `Clk`  in  1  rising-edge clock, the single clock of the block.
- `Rst`  in  1  reset, asynchronous, active-high.
- `Req0`  in  1  ALU write request; held until `Gnt0`.
- `Addr0`  in  5  ALU destination register.
- `Data0`  in  32  ALU write data.
- `Req1`  in  1  MEM write request; held until `Gnt1`.
- `Addr1`  in  5  MEM destination register.
- `Data1`  in  32  MEM write data.
- `ClrReq`  in  1  one-cycle pulse that starts the clear sequence.
- `Gnt0`  out  1  one-cycle grant pulse to requester 0.
- `Gnt1`  out  1  one-cycle grant pulse to requester 1.
- `WrEn`  out  1  register-file write enable (registered).
- `Awr`  out  5  register-file write address (registered).
- `Din`  out  32  register-file write data (registered).
- `Busy`  out  1  high while the clear sequence runs.
- `ClrDone`  out  1  one-cycle pulse on the last clear write.

## Operation
- **FSM states**
  - `IDLE`: arbitrate requesters.
  - `CLEAR`: sequence the clear writes.
- **Reset**
  - State becomes `CLEAR` if `CLEAR_ON_RESET`=1, else `IDLE`.
  - Clear counter = 0; RR pointer favours requester 0.
  - Output reset values: `WrEn`=0, `Awr`=0, `Din`=0, `Gnt0`=`Gnt1`=0, `ClrDone`=0.
  - `Busy` = (state==`CLEAR`), so it is 1 during reset when `CLEAR_ON_RESET`=1.
- **IDLE arbitration**
  - A requester is eligible when its `Req` is high and its `Gnt` is currently low. The mask prevents a double grant while the requester drops `Req`.
  - One eligible requester: it wins.
  - Both eligible: the one not granted last wins. The pointer updates on every grant.
  - On a grant, at the next edge: winner's `Gnt`=1; `Awr`/`Din` = winner's `Addr`/`Data`; `WrEn`=1.
  - Exception: `Addr`=0 with `R0_WRITABLE`=0 gives `WrEn`=0, `Gnt` still 1.
  - No grant: `WrEn`=0; `Awr`/`Din` hold their previous values.
- **CLEAR**
  - One write per cycle: `WrEn`=1, `Awr`=counter, `Din`=0. Covers addresses 0..31 inclusive, including R0.
  - `ClrDone`=1 on the cycle `Awr`=31 is presented; next state `IDLE`; counter wraps to 0.
  - No grants are issued during `CLEAR`; requests stay pending and are serviced afterwards.
- **ClrReq**
  - In `IDLE`, `ClrReq` has priority over pending requests in the same cycle: no grant, enter `CLEAR`.
  - `ClrReq` during `CLEAR` is ignored; the sequence does not restart.
- **Reset mid-clear:** asynchronous abort to the reset state. The sequence restarts from address 0 only if `CLEAR_ON_RESET`=1.

## Timing
- **Grant latency:** `Req` high in cycle t (eligible, `IDLE`) → `Gnt` and `WrEn` high in cycle t+1 → the register file captures the data at the edge ending t+1.
- **Dropping `Req`:** a requester must drop `Req` or present a new `Addr`/`Data` in the cycle after `Gnt` is seen; `Req` sampled while `Gnt`=1 is ignored.
- **Throughput:**
  - One requester: one write per 2 cycles.
  - Both requesters constantly requesting: one write per cycle, alternating 0,1,0,1.
- **Clear timing:** first clear write appears in the first cycle after reset release (or after `ClrReq` is sampled). The sequence lasts exactly 32 cycles of `WrEn`=1; `Busy` falls the cycle after `ClrDone`.
- **Grant outputs:** `Gnt0` and `Gnt1` are never both 1.

## Structure
- Package `rf_ctrl_pkg`:
  - `ADDR_W`=5, `DATA_W`=32, `REG_COUNT`=32.
  - FSM state typedef (`IDLE`, `CLEAR`).
- Sub-module `rr_arb2`: two-way round-robin picker with last-grant pointer; inputs are the masked requests; outputs are a one-hot grant. All output registers and the FSM stay in `rf_write_ctrl`.

## Test plan
- **Reset clear:** `CLEAR_ON_RESET`=1, release `Rst` → 32 cycles `WrEn`=1, `Awr`=0..31, `Din`=0; `ClrDone` at `Awr`=31; `Busy` low afterwards.
- **Single request:** `Req0`, `Addr0`=1, `Data0`=0x2232 → next cycle `Gnt0`=1, `WrEn`=1, `Awr`=1, `Din`=0x2232; a held `Req0` is not regranted in that cycle.
- **Contention:** `Req0`(`Addr`=2, 0xAAAA) and `Req1`(`Addr`=4, 0x5555) held → grants alternate 0,1,0; `WrEn` high every cycle; `Gnt0`/`Gnt1` never both 1.
- **R0 suppression:** `Req1` with `Addr1`=0, `R0_WRITABLE`=0 → `Gnt1`=1, `WrEn`=0.
- **ClrReq vs. request:** `ClrReq` and `Req0` in the same cycle → no `Gnt0`, 32 clear writes, then `Gnt0` in the cycle after `ClrDone`.
- **Reset mid-clear:** `Rst` asserted at `Awr`=10 → all outputs reset immediately; after release the sequence restarts at `Awr`=0; `ClrReq` mid-clear has no effect.
